video_luma_convert: RTL and testbench



---
 rtl/video_luma_convert_if.sv | 13 +
 rtl/video_luma_convert.sv | 159 +++++++++++++++
 tb/tb_video_luma_convert.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_luma_convert_if.sv
// AXI4-Stream video beat bundle used on both sides of video_luma_convert.
interface video_luma_convert_if #(
    parameter int DATA_W = 24
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/video_luma_convert.sv
// Two-stage RGB-to-grey converter with frame-latched coefficients and full backpressure.
// Define LUMA_ROUND_EN to round half-up before the fixed-point shift (default: truncate).
module video_luma_convert #(
    parameter int DW     = 8,
    parameter int PPC    = 1,
    parameter int COEF_W = 8
) (
    input  logic                  StreamClk,
    input  logic                  sStreamReset,
    video_luma_convert_if.slave   s_axis_video,
    video_luma_convert_if.master  m_axis_video,
    input  logic [COEF_W-1:0]     cfg_coef_r,
    input  logic [COEF_W-1:0]     cfg_coef_g,
    input  logic [COEF_W-1:0]     cfg_coef_b,
    input  logic                  cfg_bypass
);
    localparam int PIX_W  = 3 * DW;
    localparam int BEAT_W = PIX_W * PPC;
    localparam int PROD_W = DW + COEF_W;
    localparam int SUM_W  = DW + COEF_W + 2;
    localparam logic [SUM_W-1:0] Y_MAX = SUM_W'((1 << DW) - 1);

    logic en1, en2, accept, load_cfg;

    logic [COEF_W-1:0] coef_r_q, coef_r_d, coef_g_q, coef_g_d, coef_b_q, coef_b_d;
    logic              bypass_q, bypass_d;

    logic              v1_q, v1_d, byp1_q, byp1_d, last1_q, last1_d, user1_q, user1_d;
    logic [BEAT_W-1:0] raw1_q, raw1_d;
    logic [PROD_W-1:0] prod_q [PPC][3];
    logic [PROD_W-1:0] prod_d [PPC][3];

    logic              v2_q, v2_d, last2_q, last2_d, user2_q, user2_d;
    logic [BEAT_W-1:0] data2_q, data2_d;

    logic [SUM_W-1:0]  luma_sum   [PPC];
    logic [SUM_W-1:0]  luma_shift [PPC];
    logic [DW-1:0]     luma_y     [PPC];

    // The input may only advance when the stage ahead of it can drain this cycle.
    always_comb begin
        en2      = !v2_q || m_axis_video.tready;
        en1      = !v1_q || en2;
        accept   = s_axis_video.tvalid && en1;
        load_cfg = accept && s_axis_video.tuser;
    end

    assign s_axis_video.tready = en1;
    assign m_axis_video.tvalid = v2_q;
    assign m_axis_video.tdata  = data2_q;
    assign m_axis_video.tlast  = last2_q;
    assign m_axis_video.tuser  = user2_q;

    always_comb begin
        coef_r_d = coef_r_q;
        coef_g_d = coef_g_q;
        coef_b_d = coef_b_q;
        bypass_d = bypass_q;
        v1_d     = v1_q;
        byp1_d   = byp1_q;
        raw1_d   = raw1_q;
        last1_d  = last1_q;
        user1_d  = user1_q;
        prod_d   = prod_q;
        // A start-of-frame beat already converts with the values it loads.
        if (load_cfg) begin
            coef_r_d = cfg_coef_r;
            coef_g_d = cfg_coef_g;
            coef_b_d = cfg_coef_b;
            bypass_d = cfg_bypass;
        end
        if (en1) begin
            v1_d = accept;
        end
        if (accept) begin
            byp1_d  = bypass_d;
            raw1_d  = s_axis_video.tdata;
            last1_d = s_axis_video.tlast;
            user1_d = s_axis_video.tuser;
            for (int p = 0; p < PPC; p++) begin
                prod_d[p][0] = PROD_W'(s_axis_video.tdata[p*PIX_W        +: DW]) * PROD_W'(coef_r_d);
                prod_d[p][1] = PROD_W'(s_axis_video.tdata[p*PIX_W + DW   +: DW]) * PROD_W'(coef_g_d);
                prod_d[p][2] = PROD_W'(s_axis_video.tdata[p*PIX_W + 2*DW +: DW]) * PROD_W'(coef_b_d);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PPC; p++) begin
            luma_sum[p] = SUM_W'(prod_q[p][0]) + SUM_W'(prod_q[p][1]) + SUM_W'(prod_q[p][2]);
`ifdef LUMA_ROUND_EN
            luma_sum[p] = luma_sum[p] + (SUM_W'(1) << (COEF_W - 1));
`else
            luma_sum[p] = luma_sum[p];
`endif
            luma_shift[p] = luma_sum[p] >> COEF_W;
            luma_y[p]     = (luma_shift[p] > Y_MAX) ? {DW{1'b1}} : luma_shift[p][DW-1:0];
        end
    end

    always_comb begin
        v2_d    = v2_q;
        last2_d = last2_q;
        user2_d = user2_q;
        data2_d = data2_q;
        if (en2) begin
            v2_d = v1_q;
        end
        if (en2 && v1_q) begin
            last2_d = last1_q;
            user2_d = user1_q;
            if (byp1_q) begin
                data2_d = raw1_q;
            end else begin
                for (int p = 0; p < PPC; p++) begin
                    data2_d[p*PIX_W +: PIX_W] = {luma_y[p], luma_y[p], luma_y[p]};
                end
            end
        end
    end

    always_ff @(posedge StreamClk or posedge sStreamReset) begin
        if (sStreamReset) begin
            coef_r_q <= COEF_W'(77);
            coef_g_q <= COEF_W'(150);
            coef_b_q <= COEF_W'(29);
            bypass_q <= 1'b0;
            v1_q     <= 1'b0;
            byp1_q   <= 1'b0;
            raw1_q   <= '0;
            last1_q  <= 1'b0;
            user1_q  <= 1'b0;
            for (int p = 0; p < PPC; p++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_q[p][c] <= '0;
                end
            end
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            user2_q  <= 1'b0;
            data2_q  <= '0;
        end else begin
            coef_r_q <= coef_r_d;
            coef_g_q <= coef_g_d;
            coef_b_q <= coef_b_d;
            bypass_q <= bypass_d;
            v1_q     <= v1_d;
            byp1_q   <= byp1_d;
            raw1_q   <= raw1_d;
            last1_q  <= last1_d;
            user1_q  <= user1_d;
            prod_q   <= prod_d;
            v2_q     <= v2_d;
            last2_q  <= last2_d;
            user2_q  <= user2_d;
            data2_q  <= data2_d;
        end
    end
endmodule

// File: tb/tb_video_luma_convert.sv
// Bench for video_luma_convert: an 8-bit single-pixel instance for directed cases and a
// 10-bit two-pixel instance for a randomly backpressured line, both checked against a luma model.
module tb_video_luma_convert;
    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] cfg_r_a, cfg_g_a, cfg_b_a, cfg_r_b, cfg_g_b, cfg_b_b;
    logic       cfg_byp_a, cfg_byp_b;

    video_luma_convert_if #(.DATA_W(24)) sA ();
    video_luma_convert_if #(.DATA_W(24)) mA ();
    video_luma_convert_if #(.DATA_W(60)) sB ();
    video_luma_convert_if #(.DATA_W(60)) mB ();

    video_luma_convert #(.DW(8), .PPC(1), .COEF_W(8)) dut_a (
        .StreamClk(clk), .sStreamReset(rst), .s_axis_video(sA), .m_axis_video(mA),
        .cfg_coef_r(cfg_r_a), .cfg_coef_g(cfg_g_a), .cfg_coef_b(cfg_b_a), .cfg_bypass(cfg_byp_a)
    );

    video_luma_convert #(.DW(10), .PPC(2), .COEF_W(8)) dut_b (
        .StreamClk(clk), .sStreamReset(rst), .s_axis_video(sB), .m_axis_video(mB),
        .cfg_coef_r(cfg_r_b), .cfg_coef_g(cfg_g_b), .cfg_coef_b(cfg_b_b), .cfg_bypass(cfg_byp_b)
    );

    int    checks = 0;
    int    errors = 0;
    int    beats_b = 0;
    bit    rand_ready_b = 1'b0;
    beat_t q_a[$];
    beat_t q_b[$];
    int    sh_r[2], sh_g[2], sh_b[2];
    bit    sh_byp[2];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            sh_r[i] = 77; sh_g[i] = 150; sh_b[i] = 29; sh_byp[i] = 1'b0;
        end
    endtask

    function automatic int luma_of(int r, int g, int b, int cr, int cg, int cb, int dw);
        longint s;
        longint ymax;
        s = longint'(r) * cr + longint'(g) * cg + longint'(b) * cb;
`ifdef LUMA_ROUND_EN
        s = s + 128;
`endif
        s = s / 256;
        ymax = (longint'(1) << dw) - 1;
        if (s > ymax) s = ymax;
        return int'(s);
    endfunction

    function automatic logic [63:0] expect_beat(int inst, logic [63:0] d, bit u, int dw, int ppc,
                                                 int cr, int cg, int cb, bit byp);
        logic [63:0] mask;
        logic [63:0] res;
        logic [63:0] yv;
        int base;
        if (u) begin
            sh_r[inst] = cr; sh_g[inst] = cg; sh_b[inst] = cb; sh_byp[inst] = byp;
        end
        if (sh_byp[inst]) return d;
        mask = (64'd1 << dw) - 64'd1;
        res  = '0;
        for (int p = 0; p < ppc; p++) begin
            base = 3 * dw * p;
            yv = 64'(luma_of(int'((d >> base) & mask), int'((d >> (base + dw)) & mask),
                             int'((d >> (base + 2 * dw)) & mask), sh_r[inst], sh_g[inst], sh_b[inst], dw));
            res = res | ((yv | (yv << dw) | (yv << (2 * dw))) << base);
        end
        return res;
    endfunction

    task automatic apply_stimulus_a(input logic [23:0] d, input logic l, input logic u, input bit keep);
        int    n;
        beat_t b;
        n = 0;
        @(negedge clk);
        sA.tvalid = 1'b1; sA.tdata = d; sA.tlast = l; sA.tuser = u;
        #1;
        while (!sA.tready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!sA.tready) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout_a: got tready=0, expected 1 within 200 cycles");
            sA.tvalid = 1'b0;
        end else begin
            b.d = expect_beat(0, 64'(d), u, 8, 1, int'(cfg_r_a), int'(cfg_g_a), int'(cfg_b_a), cfg_byp_a);
            b.l = l; b.u = u;
            q_a.push_back(b);
            @(posedge clk); #1;
            if (!keep) sA.tvalid = 1'b0;
        end
    endtask

    task automatic apply_stimulus_b(input logic [59:0] d, input logic l, input logic u, input bit keep);
        int    n;
        beat_t b;
        n = 0;
        @(negedge clk);
        sB.tvalid = 1'b1; sB.tdata = d; sB.tlast = l; sB.tuser = u;
        #1;
        while (!sB.tready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!sB.tready) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout_b: got tready=0, expected 1 within 200 cycles");
            sB.tvalid = 1'b0;
        end else begin
            b.d = expect_beat(1, 64'(d), u, 10, 2, int'(cfg_r_b), int'(cfg_g_b), int'(cfg_b_b), cfg_byp_b);
            b.l = l; b.u = u;
            q_b.push_back(b);
            @(posedge clk); #1;
            if (!keep) sB.tvalid = 1'b0;
        end
    endtask

    task automatic wait_output_a(input string name, input logic [23:0] exp);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!mA.tvalid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!mA.tvalid) begin
            checks++; errors++;
            $display("[TB] FAIL %s: got no output beat, expected 0x%0h within 20 cycles", name, exp);
        end else begin
            check_output(name, 64'(mA.tdata), 64'(exp));
        end
    endtask

    always @(negedge clk) if (rand_ready_b) mB.tready = 1'($urandom_range(0, 1));

    // Scoreboard: every output transfer must match the oldest modelled beat, and a stalled
    // output must not move until it is taken.
    logic [63:0] prev_a, prev_b;
    bit          held_a = 1'b0, held_b = 1'b0;
    always begin
        beat_t e;
        @(negedge clk); #1;
        if (rst) begin
            held_a = 1'b0;
            held_b = 1'b0;
        end else begin
            if (held_a) check_output("stall_stable_a", 64'({mA.tvalid, mA.tlast, mA.tuser, mA.tdata}), prev_a);
            if (held_b) check_output("stall_stable_b", 64'({mB.tvalid, mB.tlast, mB.tuser, mB.tdata}), prev_b);
            if (mA.tvalid && mA.tready) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL beat_a: got unexpected beat 0x%0h, expected none", mA.tdata);
                end else begin
                    e = q_a.pop_front();
                    check_output("beat_a", 64'({mA.tlast, mA.tuser, mA.tdata}), 64'({e.l, e.u, e.d[23:0]}));
                end
            end
            if (mB.tvalid && mB.tready) begin
                beats_b++;
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL beat_b: got unexpected beat 0x%0h, expected none", mB.tdata);
                end else begin
                    e = q_b.pop_front();
                    check_output("beat_b", 64'({mB.tlast, mB.tuser, mB.tdata}), 64'({e.l, e.u, e.d[59:0]}));
                end
            end
            held_a = mA.tvalid && !mA.tready;
            held_b = mB.tvalid && !mB.tready;
            prev_a = 64'({mA.tvalid, mA.tlast, mA.tuser, mA.tdata});
            prev_b = 64'({mB.tvalid, mB.tlast, mB.tuser, mB.tdata});
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        sA.tvalid = 1'b0; sA.tdata = '0; sA.tlast = 1'b0; sA.tuser = 1'b0; mA.tready = 1'b1;
        sB.tvalid = 1'b0; sB.tdata = '0; sB.tlast = 1'b0; sB.tuser = 1'b0; mB.tready = 1'b1;
        cfg_r_a = 8'd77; cfg_g_a = 8'd150; cfg_b_a = 8'd29; cfg_byp_a = 1'b0;
        cfg_r_b = 8'd200; cfg_g_b = 8'd100; cfg_b_b = 8'd50; cfg_byp_b = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check_output("reset_tvalid", 64'(mA.tvalid), 64'd0);
        check_output("reset_tdata", 64'(mA.tdata), 64'd0);
        check_output("reset_tready", 64'(sA.tready), 64'd1);

        apply_stimulus_a(24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        check_output("latency_not_early", 64'(mA.tvalid), 64'd0);
        @(negedge clk); #1;
        check_output("latency_valid", 64'(mA.tvalid), 64'd1);
        check_output("white", 64'(mA.tdata), 64'hFFFFFF);

        apply_stimulus_a(24'h000002, 1'b0, 1'b0, 1'b0);
`ifdef LUMA_ROUND_EN
        wait_output_a("round_r2", 24'h010101);
`else
        wait_output_a("round_r2", 24'h000000);
`endif

        cfg_r_a = 8'd255; cfg_g_a = 8'd255; cfg_b_a = 8'd255;
        apply_stimulus_a(24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        wait_output_a("saturate", 24'hFFFFFF);
        apply_stimulus_a(24'h0000FF, 1'b0, 1'b0, 1'b0);
        wait_output_a("near_saturate", 24'hFEFEFE);

        cfg_r_a = 8'd77; cfg_g_a = 8'd150; cfg_b_a = 8'd29;
        apply_stimulus_a(24'h000064, 1'b0, 1'b1, 1'b0);
        wait_output_a("coef_default_r100", 24'h1E1E1E);
        cfg_r_a = 8'd255;
        apply_stimulus_a(24'h000064, 1'b0, 1'b0, 1'b0);
        wait_output_a("coef_ignored_mid_frame", 24'h1E1E1E);
        apply_stimulus_a(24'h000064, 1'b1, 1'b1, 1'b0);
`ifdef LUMA_ROUND_EN
        wait_output_a("coef_latched_sof", 24'h646464);
`else
        wait_output_a("coef_latched_sof", 24'h636363);
`endif

        cfg_r_a = 8'd77; cfg_byp_a = 1'b1;
        apply_stimulus_a(24'h123456, 1'b0, 1'b1, 1'b0);
        wait_output_a("bypass", 24'h123456);
        cfg_byp_a = 1'b0;
        apply_stimulus_a(24'h123456, 1'b0, 1'b0, 1'b0);
        wait_output_a("bypass_held", 24'h123456);
        apply_stimulus_a(24'h123456, 1'b0, 1'b1, 1'b0);
        wait_output_a("bypass_off", 24'h3A3A3A);

        // Fill both stages against a stalled sink, then reset while full.
        cfg_r_a = 8'd255; cfg_g_a = 8'd255; cfg_b_a = 8'd255;
        @(negedge clk) mA.tready = 1'b0;
        apply_stimulus_a(24'h000064, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_output("bubble_collapse_tready", 64'({mA.tvalid, sA.tready}), 64'b11);
        apply_stimulus_a(24'h000A0B, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        sA.tvalid = 1'b1; sA.tdata = 24'h777777; sA.tlast = 1'b0; sA.tuser = 1'b0;
        #1;
        check_output("full_stall_tready", 64'(sA.tready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_tvalid", 64'(mA.tvalid), 64'd0);
        check_output("async_reset_tdata", 64'(mA.tdata), 64'd0);
        sA.tvalid = 1'b0;
        q_a.delete();
        q_b.delete();
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        mA.tready = 1'b1;
        apply_stimulus_a(24'h000064, 1'b0, 1'b0, 1'b0);
        wait_output_a("post_reset_default_coefs", 24'h1E1E1E);

        rand_ready_b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            apply_stimulus_b({$urandom, $urandom}, 1'(i == 63), 1'(i == 0), i != 63);
        end
        n = 0;
        while (q_b.size() > 0 && n < 2000) begin
            @(negedge clk); n++;
        end
        rand_ready_b = 1'b0;
        @(negedge clk) mB.tready = 1'b1;
        check_output("line_drained_b", 64'(q_b.size()), 64'd0);
        check_output("line_beat_count_b", 64'(beats_b), 64'd64);
        check_output("queue_drained_a", 64'(q_a.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
